// File: rtl/cnter_down_seq.sv
// cnter_down_seq: loadable down-counting sequencer, issues indices N-1..0 over valid/ready.
// Optional macro CNTER_DOWN_SEQ_RELOAD_EN makes the sequence repeat from the captured limit.
module cnter_down_seq #(
   parameter int len = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           clr,
   input  logic [len-1:0] dataIn,
   input  logic           outReady,
   output logic           outValid,
   output logic [len-1:0] dataOut,
   output logic           last,
   output logic           busy,
   output logic           done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [len-1:0] index_q, index_d;
   logic done_q, done_d;
   logic hs;
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
   logic [len-1:0] limit_q, limit_d;
`endif
   assign hs       = (state_q == RUN) && outReady;
   assign outValid = state_q == RUN;
   assign busy     = state_q != IDLE;
   assign dataOut  = outValid ? index_q : '0;
   assign last     = outValid && (index_q == '0);
   assign done     = done_q;
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      done_d  = 1'b0;
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
      limit_d = limit_q;
`endif
      if (clr) begin
         state_d = IDLE;
         index_d = '0;
      end else begin
         case (state_q)
            IDLE: if (load) begin
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
               limit_d = dataIn;
`endif
               if (dataIn != '0) begin
                  index_d = dataIn - 1'b1;
                  state_d = RUN;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
            RUN: if (hs) begin
               if (index_q != '0) index_d = index_q - 1'b1;
               else begin
                  done_d = 1'b1;
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
                  index_d = limit_q - 1'b1;
`else
                  state_d = DONE;
`endif
               end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         index_q <= '0;
         done_q  <= 1'b0;
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
         limit_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         done_q  <= done_d;
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
         limit_q <= limit_d;
`endif
      end
   end
endmodule

// File: tb/tb_cnter_down_seq.sv
// tb_cnter_down_seq: directed bench for cnter_down_seq with hand-computed expectations.
module tb_cnter_down_seq;
   logic clk = 1'b0, reset = 1'b0, load = 1'b0, clr = 1'b0, outReady = 1'b0;
   logic [4:0] dataIn = '0;
   logic outValid, last, busy, done;
   logic [4:0] dataOut;
   int vec = 0, errs = 0;

   cnter_down_seq #(.len(5)) dut (
      .clk(clk), .reset(reset), .load(load), .clr(clr), .dataIn(dataIn),
      .outReady(outReady), .outValid(outValid), .dataOut(dataOut),
      .last(last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [4:0] n);
      dataIn = n;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load = i[0];
         outReady = i[1];
         dataIn = 5'd9;
         step();
         vec++;
         if ({outValid, dataOut, last, busy, done} !== 9'd0) begin
            errs++;
            $display("FAIL reset_outputs got %b want 0", {outValid, dataOut, last, busy, done});
         end
      end
      load = 1'b0;
      reset = 1'b1;
      step();
      outReady = 1'b1;
      start(5'd4);
      for (int i = 3; i >= 0; i--) begin
         vec++;
         if (outValid !== 1'b1 || dataOut !== 5'(i) || last !== (i == 0) || done !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL seq4_idx%0d got v=%b d=%0d l=%b dn=%b b=%b want v=1 d=%0d l=%b dn=0 b=1",
                     i, outValid, dataOut, last, done, busy, i, i == 0);
         end
         step();
      end
      vec++;
      if (done !== 1'b1 || outValid !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL seq4_done got dn=%b v=%b b=%b want 1 0 1", done, outValid, busy);
      end
      step();
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL seq4_idle got dn=%b b=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_backpressure();
      int pulses = 0;
      outReady = 1'b1;
      start(5'd3);
      step();
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         vec++;
         if (outValid !== 1'b1 || dataOut !== 5'd1 || last !== 1'b0) begin
            errs++;
            $display("FAIL bp_hold%0d got v=%b d=%0d l=%b want v=1 d=1 l=0", i, outValid, dataOut, last);
         end
         pulses += int'(done);
         step();
      end
      outReady = 1'b1;
      vec++;
      if (dataOut !== 5'd1 || outValid !== 1'b1) begin
         errs++;
         $display("FAIL bp_resume1 got d=%0d v=%b want d=1 v=1", dataOut, outValid);
      end
      step();
      vec++;
      if (dataOut !== 5'd0 || last !== 1'b1) begin
         errs++;
         $display("FAIL bp_resume0 got d=%0d l=%b want d=0 l=1", dataOut, last);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(done);
      end
      vec++;
      if (pulses != 1) begin
         errs++;
         $display("FAIL bp_done_count got %0d want 1", pulses);
      end
   endtask

   task automatic test_zero();
      start(5'd0);
      vec++;
      if (outValid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
         errs++;
         $display("FAIL zero_done got v=%b dn=%b b=%b want 0 1 1", outValid, done, busy);
      end
      step();
      vec++;
      if (done !== 1'b0 || busy !== 1'b0 || outValid !== 1'b0) begin
         errs++;
         $display("FAIL zero_idle got dn=%b b=%b v=%b want 0 0 0", done, busy, outValid);
      end
   endtask

   task automatic test_max();
      int bad = 0;
      outReady = 1'b1;
      start(5'd31);
      for (int i = 30; i >= 0; i--) begin
         if (outValid !== 1'b1 || dataOut !== 5'(i) || last !== (i == 0)) bad++;
         step();
      end
      vec++;
      if (bad != 0) begin
         errs++;
         $display("FAIL max_seq got %0d bad indices want 0", bad);
      end
      vec++;
      if (done !== 1'b1 || outValid !== 1'b0) begin
         errs++;
         $display("FAIL max_done got dn=%b v=%b want 1 0", done, outValid);
      end
      step();
   endtask

   task automatic test_ignored_load();
      outReady = 1'b1;
      start(5'd3);
      load = 1'b1;
      dataIn = 5'd7;
      for (int i = 2; i >= 0; i--) begin
         vec++;
         if (dataOut !== 5'(i) || outValid !== 1'b1) begin
            errs++;
            $display("FAIL ign_load_idx%0d got d=%0d v=%b want d=%0d v=1", i, dataOut, outValid, i);
         end
         step();
      end
      vec++;
      if (done !== 1'b1 || outValid !== 1'b0) begin
         errs++;
         $display("FAIL ign_load_done got dn=%b v=%b want 1 0", done, outValid);
      end
      load = 1'b0;
      step();
   endtask

   task automatic test_clr();
      outReady = 1'b1;
      start(5'd2);
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      vec++;
      if (done !== 1'b0 || busy !== 1'b0 || outValid !== 1'b0) begin
         errs++;
         $display("FAIL clr_final got dn=%b b=%b v=%b want 0 0 0", done, busy, outValid);
      end
      step();
      vec++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL clr_no_done got dn=%b want 0", done);
      end
   endtask

   task automatic test_async_reset();
      outReady = 1'b1;
      start(5'd4);
      step();
      #2 reset = 1'b0;
      #1;
      vec++;
      if ({outValid, dataOut, last, busy, done} !== 9'd0) begin
         errs++;
         $display("FAIL async_reset got %b want 0", {outValid, dataOut, last, busy, done});
      end
      step();
      reset = 1'b1;
      step();
      vec++;
      if (busy !== 1'b0 || outValid !== 1'b0) begin
         errs++;
         $display("FAIL async_idle got b=%b v=%b want 0 0", busy, outValid);
      end
      start(5'd2);
      vec++;
      if (dataOut !== 5'd1 || outValid !== 1'b1) begin
         errs++;
         $display("FAIL async_reload got d=%0d v=%b want 1 1", dataOut, outValid);
      end
      step();
      step();
      vec++;
      if (done !== 1'b1) begin
         errs++;
         $display("FAIL async_done got %b want 1", done);
      end
      step();
   endtask

   task automatic test_reload();
      logic [4:0] exp_d;
      logic exp_dn;
      reset = 1'b1;
      step();
      outReady = 1'b1;
      start(5'd2);
      for (int i = 0; i < 6; i++) begin
         exp_d = (i % 2 == 0) ? 5'd1 : 5'd0;
         exp_dn = (i >= 2) && (i % 2 == 0);
         vec++;
         if (outValid !== 1'b1 || dataOut !== exp_d || done !== exp_dn || busy !== 1'b1) begin
            errs++;
            $display("FAIL reload_c%0d got v=%b d=%0d dn=%b b=%b want v=1 d=%0d dn=%b b=1",
                     i, outValid, dataOut, done, busy, exp_d, exp_dn);
         end
         step();
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      vec++;
      if (outValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errs++;
         $display("FAIL reload_clr got v=%b b=%b dn=%b want 0 0 0", outValid, busy, done);
      end
   endtask

   initial begin
`ifdef CNTER_DOWN_SEQ_RELOAD_EN
      test_reload();
      test_zero();
`else
      test_reset();
      test_backpressure();
      test_zero();
      test_max();
      test_ignored_load();
      test_clr();
      test_async_reset();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/cnter_down_seq.md
Name: cnter_down_seq

Overview:
- Loadable down-counting sequencer. It is the consumer-side counterpart of the loadable up-counter.
- Accepts a trip count, then issues indices N-1 down to 0, one per valid/ready handshake. It flags the last index and pulses done when the sequence completes.
- Drives loop bounds and read-back address streams for buffers that an up-counter filled.

Parameters:
len, 5, width of the count and index datapath in bits

Ports:
clk      input   1    clock; all state updates on rising edge
reset    input   1    asynchronous, active-low reset
load     input   1    start request; sampled only in IDLE
clr      input   1    synchronous abort; returns to IDLE with no done pulse
dataIn   input   len  trip count N, captured with load
outReady input   1    downstream accepts the current index
outValid output  1    index on dataOut is valid
dataOut  output  len  current index
last     output  1    high while outValid and dataOut==0
busy     output  1    high in RUN or DONE
done     output  1    one-cycle pulse after the final handshake, or after a zero-count load

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- While reset==0:
  - state=IDLE, index register=0, limit register=0.
  - outValid=0, dataOut=0, last=0, busy=0, done=0.
- After reset deasserts, the block is in IDLE.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state and registers only; there are no combinational paths from inputs to outputs.
- IDLE:
  - outValid=0, busy=0.
  - If load=1: limit<=dataIn.
    - dataIn!=0 -> index<=dataIn-1, next state RUN.
    - dataIn==0 -> next state DONE. No index is issued.
- RUN:
  - outValid=1, busy=1, dataOut=index, last=(index==0).
  - Handshake occurs in any cycle with outValid&&outReady.
  - Handshake with index!=0 -> index<=index-1.
  - Handshake with index==0 -> next state DONE.
  - No handshake -> dataOut and last hold stable; backpressure may last indefinitely.
  - load is ignored in RUN.
- DONE:
  - done=1 for exactly one cycle, outValid=0, busy=1. Next state IDLE.
  - load is ignored in DONE.
- Latency:
  - load at edge t -> outValid=1 at cycle t+1.
  - Final handshake at edge t -> done=1 at cycle t+1.
  - done=1 at t+1 -> back in IDLE at t+2, where a new load is accepted.
- Throughput: one index per cycle with outReady held high, so N indices take N cycles.
- clr:
  - Priority over load and handshake.
  - Any state -> IDLE next cycle with index<=0 and no done pulse.
  - A clr coincident with the final handshake suppresses done.
- Arithmetic:
  - Unsigned, modulo 2^len.
  - index never decrements below 0, because the FSM exits at 0.
  - Maximum trip count is 2^len-1.
- Reset mid-operation (reset going low in any state): immediate return to reset values. Any pending done is lost.

Optional Feature:
- Macro: CNTER_DOWN_SEQ_RELOAD_EN.
- Defined:
  - On the final handshake in RUN, index<=limit-1 and the state stays RUN.
  - done still pulses one cycle after the final handshake, while outValid=1 with dataOut=limit-1. The sequence repeats until clr or reset.
  - busy stays 1 throughout.
  - A zero-count load still goes IDLE->DONE->IDLE and never loops.
- Not defined: behaviour exactly as above (RUN->DONE->IDLE). The limit register may be optimised away.

Test Plan:
- Reset: hold reset=0, toggle load and outReady -> all outputs 0. Release, then load=1 with dataIn=4 and outReady=1 -> dataOut 3,2,1,0 on consecutive cycles, last only with 0, done one cycle later, busy=0 the cycle after that.
- Backpressure: dataIn=3, outReady low for 5 cycles at dataOut=1 -> dataOut holds 1 and outValid holds 1 throughout. Sequence resumes 1,0 and done fires once.
- Zero and maximum counts:
  - dataIn=0 -> no outValid, done=1 the cycle after load.
  - dataIn=31 (len=5) -> 31 indices, 30 down to 0.
- Ignored load and clr:
  - load with dataIn=7 during RUN of dataIn=3 -> sequence stays 2,1,0.
  - clr on the final handshake cycle -> IDLE, done never asserts.
- Async reset mid-RUN: pull reset low between clock edges at dataOut=2 -> outputs drop to 0 without waiting for a clock edge. After release the block is in IDLE and a new load works.
- CNTER_DOWN_SEQ_RELOAD_EN defined: dataIn=2, outReady=1 -> dataOut 1,0,1,0,1,0..., done pulsed coincident with each reloaded 1. clr stops the sequence.
